// File: rtl/npu_pkg.sv
// Shared NPU definitions: operand-feeder FSM states, default element width
// and a helper that sizes step counters.
package npu_pkg;

    localparam int NPU_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } feeder_state_t;

    // Bits needed to hold 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/feeder_lane_sel.sv
// Combinational lane select: returns the element one lane presents on step t,
// delayed by its lane index when SKEW is set, plus a real-element flag.
module feeder_lane_sel #(
    parameter int K    = 4,
    parameter int DW   = 8,
    parameter int TW   = 3,
    parameter int LANE = 0,
    parameter bit SKEW = 1'b1
) (
    input  logic [K-1:0][DW-1:0] elems,
    input  logic [TW-1:0]        t,
    output logic [DW-1:0]        elem,
    output logic                 vld
);

    int rel;

    // NOTE: every output gets a default before the search loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rel  = SKEW ? int'(t) - LANE : int'(t);
        vld  = 1'b0;
        elem = '0;
        for (int k = 0; k < K; k++) begin
            if (rel == k) begin
                vld  = 1'b1;
                elem = elems[k];
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic-array operand feeder: captures A (NxK) and B (KxN), then streams one
// beat per accepted handshake. Define SYSTOLIC_FEEDER_SKEW_EN for diagonal skew.
module systolic_feeder
    import npu_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int DW = NPU_DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N-1:0][K-1:0][DW-1:0] a_mat,
    input  logic [K-1:0][N-1:0][DW-1:0] b_mat,
    input  logic                        out_ready,
    output logic [N-1:0][DW-1:0]        a_out,
    output logic [N-1:0][DW-1:0]        b_out,
    output logic [N-1:0]                a_lane_vld,
    output logic [N-1:0]                b_lane_vld,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done
);

`ifdef SYSTOLIC_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
    localparam int T    = K + N - 1;
`else
    localparam bit SKEW = 1'b0;
    localparam int T    = K;
`endif
    localparam int            TW     = cnt_width(K + N - 1);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);

    feeder_state_t               state_q, state_d;
    logic [N-1:0][K-1:0][DW-1:0] a_q;
    logic [K-1:0][N-1:0][DW-1:0] b_q;
    logic [N-1:0][K-1:0][DW-1:0] b_cols;
    logic [TW-1:0]               t_q;
    logic [N-1:0][DW-1:0]        a_sel, b_sel;
    logic [N-1:0]                a_sel_vld, b_sel_vld;
    logic                        beat_fire;

    assign beat_fire = (state_q == STREAM) && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    // NOTE: operand registers are reset as well, so an aborted run leaves no stale matrix behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            if (state_q == LOAD) begin
                t_q <= '0;
            end else if (beat_fire && t_q != T_LAST) begin
                t_q <= t_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && t_q == T_LAST) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // B lanes walk down a column, so regroup B column-major for the selectors.
    for (genvar l = 0; l < N; l++) begin : g_lane
        for (genvar k = 0; k < K; k++) begin : g_col
            assign b_cols[l][k] = b_q[k][l];
        end

        feeder_lane_sel #(.K(K), .DW(DW), .TW(TW), .LANE(l), .SKEW(SKEW)) u_a_sel (
            .elems (a_q[l]),
            .t     (t_q),
            .elem  (a_sel[l]),
            .vld   (a_sel_vld[l])
        );

        feeder_lane_sel #(.K(K), .DW(DW), .TW(TW), .LANE(l), .SKEW(SKEW)) u_b_sel (
            .elems (b_cols[l]),
            .t     (t_q),
            .elem  (b_sel[l]),
            .vld   (b_sel_vld[l])
        );
    end

    assign a_out      = out_valid ? a_sel     : '0;
    assign b_out      = out_valid ? b_sel     : '0;
    assign a_lane_vld = out_valid ? a_sel_vld : '0;
    assign b_lane_vld = out_valid ? b_sel_vld : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a 2x2 instance for directed runs and a
// 4-lane, K=3 instance for random matrices with random back-pressure.
module tb_systolic_feeder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  avld;
        logic [3:0]  bvld;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic                  start2, out_ready2;
    logic [1:0][1:0][7:0]  a2_mat, b2_mat;
    logic [1:0][7:0]       a2_out, b2_out;
    logic [1:0]            a2_vld, b2_vld;
    logic                  out_valid2, busy2, done2;

    logic                  start4, out_ready4;
    logic [3:0][2:0][7:0]  a4_mat;
    logic [2:0][3:0][7:0]  b4_mat;
    logic [3:0][7:0]       a4_out, b4_out;
    logic [3:0]            a4_vld, b4_vld;
    logic                  out_valid4, busy4, done4;

    beat_t q2[$];
    beat_t q4[$];
    beat_t e2, e4;
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(2), .K(2), .DW(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_mat(a2_mat), .b_mat(b2_mat),
        .out_ready(out_ready2), .a_out(a2_out), .b_out(b2_out),
        .a_lane_vld(a2_vld), .b_lane_vld(b2_vld), .out_valid(out_valid2),
        .busy(busy2), .done(done2)
    );

    systolic_feeder #(.N(4), .K(3), .DW(8)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_mat(a4_mat), .b_mat(b4_mat),
        .out_ready(out_ready4), .a_out(a4_out), .b_out(b4_out),
        .a_lane_vld(a4_vld), .b_lane_vld(b4_vld), .out_valid(out_valid4),
        .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbeats(input int n, input int k);
`ifdef SYSTOLIC_FEEDER_SKEW_EN
        return k + n - 1;
`else
        return k;
`endif
    endfunction

    // Reference: lane l shows A[l][t-l] / B[t-l][l] (skewed) or A[l][t] / B[t][l].
    function automatic beat_t model(input int n, input int k, input int t,
                                    input logic [3:0][3:0][7:0] am,
                                    input logic [3:0][3:0][7:0] bm);
        beat_t e = '0;
        int    rel;
        for (int l = 0; l < n; l++) begin
`ifdef SYSTOLIC_FEEDER_SKEW_EN
            rel = t - l;
`else
            rel = t;
`endif
            if (rel >= 0 && rel < k) begin
                e.a[l*8 +: 8] = am[l[1:0]][rel[1:0]];
                e.b[l*8 +: 8] = bm[rel[1:0]][l[1:0]];
                e.avld[l]     = 1'b1;
                e.bvld[l]     = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic push2();
        logic [3:0][3:0][7:0] am = '0;
        logic [3:0][3:0][7:0] bm = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                am[i][j] = a2_mat[i][j];
                bm[i][j] = b2_mat[i][j];
            end
        for (int t = 0; t < nbeats(2, 2); t++) q2.push_back(model(2, 2, t, am, bm));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid2) begin
                if (q2.size() == 0) begin
                    check("n2_extra_beat", 1'b1, 1'b0);
                end else begin
                    e2 = q2[0];
                    check("n2_a_out", a2_out, e2.a);
                    check("n2_b_out", b2_out, e2.b);
                    check("n2_vld", {a2_vld, b2_vld}, {e2.avld[1:0], e2.bvld[1:0]});
                    if (out_ready2) void'(q2.pop_front());
                end
            end else begin
                check("n2_idle_zero", {a2_out, b2_out, a2_vld, b2_vld}, '0);
            end
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    check("n4_extra_beat", 1'b1, 1'b0);
                end else begin
                    e4 = q4[0];
                    check("n4_a_out", a4_out, e4.a);
                    check("n4_b_out", b4_out, e4.b);
                    check("n4_vld", {a4_vld, b4_vld}, {e4.avld, e4.bvld});
                    if (out_ready4) void'(q4.pop_front());
                end
            end else begin
                check("n4_idle_zero", {a4_out, b4_out, a4_vld, b4_vld}, '0);
            end
        end
    end

    // One 2x2 run; beat stall_at is held for stall_len cycles. Inputs are
    // scrambled after capture to show they are don't-care while busy.
    task automatic run2(input int stall_at, input int stall_len, output int busy_cyc);
        int  beat    = 0;
        int  stalled = 0;
        int  cyc     = 0;
        bit  fin     = 1'b0;
        logic [1:0][1:0][7:0] sa = a2_mat;
        logic [1:0][1:0][7:0] sb = b2_mat;
        push2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2   = 1'b0;
        a2_mat   = ~sa;
        b2_mat   = ~sb;
        busy_cyc = 0;
        while (!fin && cyc < 200) begin
            out_ready2 = !(out_valid2 && beat == stall_at && stalled < stall_len);
            if (out_valid2 && !out_ready2) stalled++;
            @(negedge clk);
            if (busy2) busy_cyc++;
            if (out_valid2 && out_ready2) beat++;
            if (done2) begin
                fin = 1'b1;
                check("n2_done_valid_low", out_valid2, 1'b0);
                check("n2_done_beats", beat, nbeats(2, 2));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("n2_done_seen", fin, 1'b1);
        check("n2_done_one_cycle", done2, 1'b0);
        check("n2_idle_busy", busy2, 1'b0);
        check("n2_queue_drained", q2.size(), 0);
        out_ready2 = 1'b1;
        a2_mat     = sa;
        b2_mat     = sb;
    endtask

    task automatic run4();
        logic [3:0][3:0][7:0] am = '0;
        logic [3:0][3:0][7:0] bm = '0;
        int beat = 0;
        int cyc  = 0;
        bit fin  = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 3; k++) begin
                a4_mat[r][k] = 8'($urandom_range(1, 255));
                b4_mat[k][r] = 8'($urandom_range(1, 255));
                am[r][k]     = a4_mat[r][k];
                bm[k][r]     = b4_mat[k][r];
            end
        for (int t = 0; t < nbeats(4, 3); t++) q4.push_back(model(4, 3, t, am, bm));
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        while (!fin && cyc < 200) begin
            out_ready4 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid4 && out_ready4) beat++;
            if (done4) begin
                fin = 1'b1;
                check("n4_beat_count", beat, nbeats(4, 3));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("n4_done_seen", fin, 1'b1);
        check("n4_queue_drained", q4.size(), 0);
        out_ready4 = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, stl, dones, since, cyc;
        rst        = 1'b1;
        start2     = 1'b0;
        start4     = 1'b0;
        out_ready2 = 1'b1;
        out_ready4 = 1'b1;
        a2_mat     = '0;
        b2_mat     = '0;
        a4_mat     = '0;
        b4_mat     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_n2_ctrl", {busy2, done2, out_valid2}, 3'b000);
        check("rst_n2_out", {a2_out, b2_out, a2_vld, b2_vld}, '0);
        check("rst_n4_ctrl", {busy4, done4, out_valid4}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        a2_mat[0][0] = 8'd1; a2_mat[0][1] = 8'd2; a2_mat[1][0] = 8'd3; a2_mat[1][1] = 8'd4;
        b2_mat[0][0] = 8'd5; b2_mat[0][1] = 8'd6; b2_mat[1][0] = 8'd7; b2_mat[1][1] = 8'd8;
        run2(-1, 0, base);
        check("busy_cycles_base", base, 1 + nbeats(2, 2));

        run2(1, 3, stl);
        check("busy_cycles_stall", stl, base + 3);

        // Abort during beat 1, then replay from beat 0.
        push2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {busy2, done2, out_valid2}, 3'b000);
        check("rst_mid_out", {a2_out, b2_out, a2_vld, b2_vld}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        q2.delete();
        @(posedge clk); #1;
        check("rst_stays_idle", busy2, 1'b0);
        run2(-1, 0, base);

        // start held high: ignored while busy, then accepted right after DONE.
        push2();
        push2();
        start2 = 1'b1;
        dones  = 0;
        since  = -1;
        cyc    = 0;
        while (dones < 2 && cyc < 200) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (since == 1) check("b2b_idle_after_done", busy2, 1'b0);
            if (since == 2) check("b2b_load_state", {busy2, out_valid2}, 2'b10);
            if (done2) begin
                dones++;
                if (dones == 1) since = 0;
                else start2 = 1'b0;
            end
            cyc++;
        end
        @(posedge clk); #1;
        check("b2b_done_count", dones, 2);
        check("b2b_queue_drained", q2.size(), 0);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                a2_mat[i][j] = 8'($urandom_range(0, 255));
                b2_mat[i][j] = 8'($urandom_range(0, 255));
            end
        run2(0, 2, stl);
        check("busy_cycles_rand", stl, 1 + nbeats(2, 2) + 2);

        for (int i = 0; i < 3; i++) run4();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
